// File: rtl/hex_scan_ctrl.sv
// Multiplexed hex display scanner: sequences digits with dead-time, blanks leading
// zeros and commits double-buffered values only at frame boundaries.
module hex_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 50000,
  parameter int unsigned DEAD       = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    lz_blank,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              hex_digit,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam int unsigned IW   = $clog2(NUM_DIGITS);
  localparam int unsigned MAXC = (DWELL > DEAD) ? DWELL : DEAD;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {DEAD_S, DRIVE_S} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  started_q, started_d;
  logic [W-1:0]          shadow_q, shadow_d;
  logic [W-1:0]          active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [3:0]            hex_q, hex_d;
  logic                  boundary;
  logic                  all_zero;
  logic                  blanked;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    started_d    = started_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    anode_d      = '1;
    hex_d        = hex_q;
    boundary     = 1'b0;
    all_zero     = 1'b1;
    blanked      = 1'b0;

    if (en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (state_q == DEAD_S) begin
        state_d   = DRIVE_S;
        cnt_d     = CW'(DWELL - 1);
        started_d = 1'b1;
        // The dead slot straight after reset leads into digit 0 without a wrap.
        if (!started_q) begin
          idx_d = '0;
        end else if (idx_q == IW'(NUM_DIGITS - 1)) begin
          idx_d    = '0;
          boundary = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        state_d = DEAD_S;
        cnt_d   = CW'(DEAD - 1);
      end
    end

    frame_done_d = boundary;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    // Walk from the top digit down so all_zero covers nibbles N-1..i.
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      all_zero = all_zero && (active_d[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      if (idx_d == IW'(NUM_DIGITS - 1 - j)) blanked = lz_blank && all_zero;
    end

    if (en && state_d == DRIVE_S) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IW'(i)) begin
          hex_d      = active_d[4*i +: 4];
          anode_d[i] = blanked;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DEAD_S;
      idx_q        <= '0;
      cnt_q        <= '0;
      started_q    <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      anode_q      <= '1;
      hex_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      started_q    <= started_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      anode_q      <= anode_d;
      hex_q        <= hex_d;
    end
  end

  assign hex_digit  = hex_q;
  assign anode_n    = anode_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
